// File: rtl/seg_disp_arb.sv
// seg_disp_arb
// Chooses which of three 8-bit values is shown on the 7-segment display.
// Source 0 is the background value and is shown whenever no overlay is active.
// Sources 1 and 2 are overlays. A request pulse captures the overlay value,
// which is then shown for HOLD ticks of CE.
// Priority is source 2 > source 1 > source 0.
//
// Optional build macro: SEG_ARB_PEND_EN
//   Defined:   a source-1 request blocked by source 2 is parked in a
//              one-entry pending register and acknowledged. The pending
//              entry is shown when source 2 expires.
//   Undefined: the pending register does not exist, and a blocked source-1
//              request is dropped with NACK[0].
//
// State table
//   state | meaning
//   IDLE  | background VAL0 is refreshed into DISP_VAL every cycle
//   HOLD  | an overlay is shown, and cnt counts CE ticks down to expiry

module seg_disp_arb #(
    parameter int unsigned HOLD = 1000,
    parameter int unsigned CW   = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic [7:0] VAL0,
    input  logic [1:0] REQ,
    input  logic [7:0] VAL1,
    input  logic [7:0] VAL2,
    output logic [7:0] DISP_VAL,
    output logic [1:0] DISP_SRC,
    output logic [1:0] ACK,
    output logic [1:0] NACK,
    output logic       BUSY
);

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_HOLD = 1'b1;

    localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    localparam logic [1:0]    SRC_BG  = 2'd0;
    localparam logic [1:0]    SRC_OV1 = 2'd1;
    localparam logic [1:0]    SRC_OV2 = 2'd2;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    disp_val_q, disp_val_d;
    logic [1:0]    disp_src_q, disp_src_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    nack_q, nack_d;

`ifdef SEG_ARB_PEND_EN
    logic          pend_vld_q, pend_vld_d;
    logic [7:0]    pend_val_q, pend_val_d;
`endif

    logic          in_hold;
    logic          expire;
    logic          blk1;

    // Decode the arbitration conditions used by the next-state logic.
    // The overlay expires when the last CE tick of the hold time arrives.
    // Source 1 is blocked when source 2 wins in the same cycle, or when
    // source 2 is on screen and is not expiring in this cycle.
    always_comb begin
        in_hold = (state_q == ST_HOLD);
        expire  = in_hold && CE && (cnt_q == CNT_ONE);
        blk1    = REQ[0] && (REQ[1] || (in_hold && (disp_src_q == SRC_OV2) && !expire));
    end

    // Next-state logic.
    // A grant takes priority over expiry. Expiry takes priority over the
    // plain countdown.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        disp_val_d = disp_val_q;
        disp_src_d = disp_src_q;
        ack_d      = 2'b00;
        nack_d     = 2'b00;
`ifdef SEG_ARB_PEND_EN
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
`endif

        if (REQ[1]) begin
            // Source 2 always wins. A source 1 overlay on screen is
            // discarded and is not parked in the pending register.
            state_d    = ST_HOLD;
            cnt_d      = CNT_HOLD;
            disp_val_d = VAL2;
            disp_src_d = SRC_OV2;
            ack_d[1]   = 1'b1;
        end else if (REQ[0] && !blk1) begin
            // This grant also supersedes any parked source 1 value.
            // That case only arises when source 2 is expiring.
            state_d    = ST_HOLD;
            cnt_d      = CNT_HOLD;
            disp_val_d = VAL1;
            disp_src_d = SRC_OV1;
            ack_d[0]   = 1'b1;
`ifdef SEG_ARB_PEND_EN
            pend_vld_d = 1'b0;
`endif
        end else if (in_hold) begin
            if (expire) begin
`ifdef SEG_ARB_PEND_EN
                if (pend_vld_q) begin
                    // The parked entry was already acknowledged when it
                    // was stored, so it is shown here without a new ACK.
                    cnt_d      = CNT_HOLD;
                    disp_val_d = pend_val_q;
                    disp_src_d = SRC_OV1;
                    pend_vld_d = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                    cnt_d      = CNT_ZERO;
                    disp_val_d = VAL0;
                    disp_src_d = SRC_BG;
                end
`else
                state_d    = ST_IDLE;
                cnt_d      = CNT_ZERO;
                disp_val_d = VAL0;
                disp_src_d = SRC_BG;
`endif
            end else if (CE) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            disp_val_d = VAL0;
            disp_src_d = SRC_BG;
        end

        // A blocked source 1 request is parked or dropped. The value
        // stored last replaces any older parked value.
        if (blk1) begin
`ifdef SEG_ARB_PEND_EN
            pend_vld_d = 1'b1;
            pend_val_d = VAL1;
            ack_d[0]   = 1'b1;
`else
            nack_d[0]  = 1'b1;
`endif
        end
    end

    // State and output registers, with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            disp_val_q <= 8'd0;
            disp_src_q <= SRC_BG;
            ack_q      <= 2'b00;
            nack_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            disp_val_q <= disp_val_d;
            disp_src_q <= disp_src_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
        end
    end

`ifdef SEG_ARB_PEND_EN
    // Pending register for a source 1 request that source 2 blocked.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_vld_q <= 1'b0;
            pend_val_q <= 8'd0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
        end
    end
`endif

    // Outputs are driven directly from the registers, so they cannot glitch.
    always_comb begin
        DISP_VAL = disp_val_q;
        DISP_SRC = disp_src_q;
        ACK      = ack_q;
        NACK     = nack_q;
        BUSY     = (state_q == ST_HOLD);
    end

endmodule
